// File: rtl/regarb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regarb_pkg
// Purpose  : Shared sizes, FSM state type and requester IDs for the
//            register-file write arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package regarb_pkg;

    localparam int DATA_SIZE_DFLT = 32;
    localparam int ADDR_SIZE_DFLT = 5;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    // Pointer value naming the requester that wins the next tie
    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_MEM = 1'b1;

endpackage : regarb_pkg
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Purpose  : Two-input round-robin arbiter; the pointer flips only after a grant.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import regarb_pkg::*;
(
    input  logic Clk,
    input  logic Rst,
    input  logic Req0,
    input  logic Req1,
    input  logic Hold,
    output logic Gnt0,
    output logic Gnt1
);

    logic r_pri;

    always_comb begin
        Gnt0 = 1'b0;
        Gnt1 = 1'b0;
        if (!Rst && !Hold) begin
            if (Req0 && (!Req1 || (r_pri == REQ_ALU)))
                Gnt0 = 1'b1;
            else if (Req1)
                Gnt1 = 1'b1;
        end
    end

    // Whoever was just granted loses the next tie
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)
            r_pri <= REQ_ALU;
        else if (Gnt0)
            r_pri <= REQ_MEM;
        else if (Gnt1)
            r_pri <= REQ_ALU;
    end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Arbitrates ALU and load-unit writebacks onto one registered
//            register-file write port. Define REGARB_BYPASS_EN for read forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter
    import regarb_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DFLT,
    parameter int ADDR_SIZE = ADDR_SIZE_DFLT
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 AluReq,
    input  logic [ADDR_SIZE-1:0] AluAddr,
    input  logic [DATA_SIZE-1:0] AluData,
    output logic                 AluGnt,
    input  logic                 MemReq,
    input  logic [ADDR_SIZE-1:0] MemAddr,
    input  logic [DATA_SIZE-1:0] MemData,
    output logic                 MemGnt,
    input  logic                 Stall,
`ifdef REGARB_BYPASS_EN
    input  logic [ADDR_SIZE-1:0] RdAddrA,
    input  logic [ADDR_SIZE-1:0] RdAddrB,
    input  logic [DATA_SIZE-1:0] RfDataA,
    input  logic [DATA_SIZE-1:0] RfDataB,
    output logic [DATA_SIZE-1:0] FwdDataA,
    output logic [DATA_SIZE-1:0] FwdDataB,
`endif
    output logic                 WriteEnable,
    output logic [ADDR_SIZE-1:0] WriteAddr,
    output logic [DATA_SIZE-1:0] WriteData,
    output logic                 Busy
);

    state_t               r_state;
    state_t               w_next;
    logic [ADDR_SIZE-1:0] r_addr;
    logic [DATA_SIZE-1:0] r_data;
    logic                 w_alu_xfer;
    logic                 w_mem_xfer;
    logic [ADDR_SIZE-1:0] w_addr;
    logic [DATA_SIZE-1:0] w_data;
    logic                 w_wr;

    rr_arbiter2 u_arb (
        .Clk  (Clk),
        .Rst  (Rst),
        .Req0 (AluReq),
        .Req1 (MemReq),
        .Hold (Stall),
        .Gnt0 (AluGnt),
        .Gnt1 (MemGnt)
    );

    assign w_alu_xfer = AluReq && AluGnt;
    assign w_mem_xfer = MemReq && MemGnt;
    assign w_addr     = w_mem_xfer ? MemAddr : AluAddr;
    assign w_data     = w_mem_xfer ? MemData : AluData;
    // Writes to register 0 are accepted but never reach the output stage
    assign w_wr       = (w_alu_xfer || w_mem_xfer) && (w_addr != '0);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = w_wr ? WRITE : IDLE;
            WRITE:   w_next = w_wr ? WRITE : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_addr <= '0;
            r_data <= '0;
        end else if (w_wr) begin
            r_addr <= w_addr;
            r_data <= w_data;
        end
    end

    assign Busy        = (r_state == WRITE);
    assign WriteEnable = Busy;
    assign WriteAddr   = r_addr;
    assign WriteData   = r_data;

`ifdef REGARB_BYPASS_EN
    assign FwdDataA = (WriteEnable && (RdAddrA == WriteAddr) && (RdAddrA != '0)) ? WriteData : RfDataA;
    assign FwdDataB = (WriteEnable && (RdAddrB == WriteAddr) && (RdAddrB != '0)) ? WriteData : RfDataB;
`endif

endmodule : regfile_write_arbiter
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_arbiter
// Purpose  : Self-checking bench: directed scenarios plus random traffic
//            against a transaction-level model of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        AluReq = 1'b0, MemReq = 1'b0, Stall = 1'b0;
    logic [4:0]  AluAddr = '0, MemAddr = '0;
    logic [31:0] AluData = '0, MemData = '0;
    logic        AluGnt, MemGnt, WriteEnable, Busy;
    logic [4:0]  WriteAddr;
    logic [31:0] WriteData;
`ifdef REGARB_BYPASS_EN
    logic [4:0]  RdAddrA = '0, RdAddrB = '0;
    logic [31:0] RfDataA = '0, RfDataB = '0;
    logic [31:0] FwdDataA, FwdDataB;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Model: pending transactions per requester, who won last, expected output stage
    bit          pa, pm, last_mem;
    logic [4:0]  aa, ma, exp_addr;
    logic [31:0] ad, md, exp_data;
    bit          exp_we;
    int          wait_a, wait_m;

    regfile_write_arbiter dut (
        .Clk(Clk), .Rst(Rst),
        .AluReq(AluReq), .AluAddr(AluAddr), .AluData(AluData), .AluGnt(AluGnt),
        .MemReq(MemReq), .MemAddr(MemAddr), .MemData(MemData), .MemGnt(MemGnt),
        .Stall(Stall),
`ifdef REGARB_BYPASS_EN
        .RdAddrA(RdAddrA), .RdAddrB(RdAddrB), .RfDataA(RfDataA), .RfDataB(RfDataB),
        .FwdDataA(FwdDataA), .FwdDataB(FwdDataB),
`endif
        .WriteEnable(WriteEnable), .WriteAddr(WriteAddr), .WriteData(WriteData),
        .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        pa = 0; pm = 0; last_mem = 1; exp_we = 0;
        exp_addr = '0; exp_data = '0; wait_a = 0; wait_m = 0;
    endtask

    task automatic check_outputs();
        check("we", {63'd0, WriteEnable}, {63'd0, exp_we});
        check("busy", {63'd0, Busy}, {63'd0, exp_we});
        if (exp_we) begin
            check("waddr", {59'd0, WriteAddr}, {59'd0, exp_addr});
            check("wdata", {32'd0, WriteData}, {32'd0, exp_data});
        end
    endtask

    // One clock: check the output stage, offer new requests, check grants, advance the model
    task automatic step(input bit an, input logic [4:0] naa, input logic [31:0] nad,
                        input bit mn, input logic [4:0] nma, input logic [31:0] nmd,
                        input bit st);
        bit ga, gm;
        @(negedge Clk);
        check_outputs();
        if (!pa && an) begin pa = 1; aa = naa; ad = nad; wait_a = 0; end
        if (!pm && mn) begin pm = 1; ma = nma; md = nmd; wait_m = 0; end
        AluReq = pa; AluAddr = pa ? aa : 5'($urandom); AluData = pa ? ad : $urandom;
        MemReq = pm; MemAddr = pm ? ma : 5'($urandom); MemData = pm ? md : $urandom;
        Stall  = st;
`ifdef REGARB_BYPASS_EN
        RdAddrA = ($urandom % 2 == 0) ? exp_addr : 5'($urandom);
        RdAddrB = 5'($urandom % 4);
        RfDataA = $urandom; RfDataB = $urandom;
`endif
        #1;
`ifdef REGARB_BYPASS_EN
        check("fwdA", {32'd0, FwdDataA},
              {32'd0, (exp_we && RdAddrA == exp_addr && RdAddrA != 0) ? exp_data : RfDataA});
        check("fwdB", {32'd0, FwdDataB},
              {32'd0, (exp_we && RdAddrB == exp_addr && RdAddrB != 0) ? exp_data : RfDataB});
`endif
        ga = !st && pa && (!pm || last_mem);
        gm = !st && pm && !ga;
        check("alu_gnt", {63'd0, AluGnt}, {63'd0, ga});
        check("mem_gnt", {63'd0, MemGnt}, {63'd0, gm});
        exp_we = 0;
        if (ga) begin
            check("alu_starve", wait_a, (wait_a < 2) ? wait_a : 1);
            exp_we = (aa != 0);
            if (exp_we) begin exp_addr = aa; exp_data = ad; end
            pa = 0; last_mem = 0;
        end else if (gm) begin
            check("mem_starve", wait_m, (wait_m < 2) ? wait_m : 1);
            exp_we = (ma != 0);
            if (exp_we) begin exp_addr = ma; exp_data = md; end
            pm = 0; last_mem = 1;
        end
        if (!st && pa && !ga) wait_a++;
        if (!st && pm && !gm) wait_m++;
    endtask

    task automatic idle_step();
        step(0, '0, '0, 0, '0, '0, 0);
    endtask

    initial begin
        model_reset();
        // Reset state, grants suppressed while reset is high
        #12;
        check("rst_we", {63'd0, WriteEnable}, 64'd0);
        check("rst_busy", {63'd0, Busy}, 64'd0);
        check("rst_waddr", {59'd0, WriteAddr}, 64'd0);
        check("rst_wdata", {32'd0, WriteData}, 64'd0);
        AluReq = 1; MemReq = 1; #1;
        check("rst_alu_gnt", {63'd0, AluGnt}, 64'd0);
        check("rst_mem_gnt", {63'd0, MemGnt}, 64'd0);
        AluReq = 0; MemReq = 0;
        @(negedge Clk); Rst = 0;

        // Single ALU write, then asynchronous reset while it sits in the output stage
        step(1, 5'd3, 32'hDEAD_BEEF, 0, '0, '0, 0);
        @(negedge Clk);
        check_outputs();
        AluReq = 1; AluAddr = 5'd9; MemReq = 1; MemAddr = 5'd4;
        #2 Rst = 1;
        #1;
        check("arst_we", {63'd0, WriteEnable}, 64'd0);
        check("arst_busy", {63'd0, Busy}, 64'd0);
        check("arst_waddr", {59'd0, WriteAddr}, 64'd0);
        check("arst_wdata", {32'd0, WriteData}, 64'd0);
        check("arst_gnt", {62'd0, AluGnt, MemGnt}, 64'd0);
        AluReq = 0; MemReq = 0;
        #1 Rst = 0;
        model_reset();

        // Both requesting right after reset: ALU, MEM, ALU, MEM
        for (int i = 0; i < 4; i++)
            step(1, 5'(i + 1), 32'h1000 + i, 1, 5'(i + 10), 32'h2000 + i, 0);
        idle_step(); idle_step();

        // Load to register 0 is granted but discarded
        step(0, '0, '0, 1, 5'd0, 32'h55, 0);
        idle_step();

        // Stall for 3 cycles with both pending, then release
        for (int i = 0; i < 3; i++)
            step(1, 5'd7, 32'h1234, 1, 5'd7, 32'h5678, 1);
        step(0, '0, '0, 0, '0, '0, 0);
        step(0, '0, '0, 0, '0, '0, 0);
        idle_step();

        // Random traffic, small address range so same-register writes collide
        for (int i = 0; i < 400; i++)
            step($urandom % 3 != 0, 5'($urandom_range(0, 7)), $urandom,
                 $urandom % 3 != 0, 5'($urandom_range(0, 7)), $urandom,
                 $urandom % 5 == 0);
        for (int i = 0; i < 4; i++) idle_step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_regfile_write_arbiter
`default_nettype wire
